// File: rtl/beacon_report_gen.sv
// Beacon report transmitter: emits a 6-word msg_type 4'he report on a periodic tick
// or after every beacon_update_master toggle, snapshotting the node registers at W0.
module beacon_report_gen (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [47:0]  in_local_mac_id,
    input  logic [47:0]  in_controller_mac,
    input  logic [31:0]  in_report_period,
    input  logic         beacon_update_master,
    input  logic [31:0]  in_time_slot_period,
    input  logic         in_direction,
    input  logic [31:0]  in_token_bucket_para,
    input  logic [47:0]  in_direct_mac_addr,
    input  logic [47:0]  in_global_time,
    input  logic         in_lr_fifo_alf,
    output logic [133:0] out_lr_data,
    output logic         out_lr_data_wr,
    output logic         out_lr_data_valid,
    output logic         out_lr_data_valid_wr,
    output logic [15:0]  out_report_cnt
);

    localparam int unsigned DATA_W  = 134;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PER_W   = 32;
    localparam int unsigned WCNT_W  = 3;

    localparam logic [7:0]  LMID            = 8'd12;
    localparam logic [3:0]  MSG_TYPE_REPORT = 4'he;
    localparam logic [15:0] ETH_TYPE        = 16'h1662;
    localparam logic [11:0] BYTE_LEN        = 12'd96;

    localparam logic [WCNT_W-1:0] WCNT_TAIL = 3'd5;
    localparam logic [WCNT_W-1:0] WCNT_GAP  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                pend_q, pend_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic                bum_q;
    logic [CNT_W-1:0]    report_cnt_q, report_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_q, wr_d;
    logic                valid_q, valid_d;
    logic                valid_wr_q, valid_wr_d;

    logic [47:0]         snap_lmac_q;
    logic [47:0]         snap_cmac_q;
    logic [31:0]         snap_tsp_q;
    logic                snap_dir_q;
    logic [31:0]         snap_tbp_q;
    logic [47:0]         snap_dmac_q;
    logic [47:0]         snap_gt_q;

    logic                tick_c;
    logic                trig_c;
    logic                issue_w0_c;

    // Period tick: a lowered period below the running count fires on the next edge.
    always_comb begin
        tick_c    = 1'b0;
        per_cnt_d = '0;
        if (in_report_period != '0) begin
            tick_c = (per_cnt_q >= (in_report_period - PER_W'(1)));
            if (!tick_c) begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end
        end
    end

    assign trig_c = bum_q ^ beacon_update_master;

    // A request arriving on the W0 edge re-arms pending so exactly one more report follows.
    always_comb begin
        if (issue_w0_c) begin
            pend_d = tick_c | trig_c;
        end else begin
            pend_d = pend_q | tick_c | trig_c;
        end
    end

    // Next state and registered packet outputs; W0 leaves IDLE/WAIT, SEND carries W1..W5 plus one gap cycle.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        issue_w0_c   = 1'b0;
        data_d       = '0;
        wr_d         = 1'b0;
        valid_d      = 1'b0;
        valid_wr_d   = 1'b0;
        report_cnt_d = report_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    if (in_lr_fifo_alf) begin
                        state_d = ST_WAIT;
                    end else begin
                        issue_w0_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!in_lr_fifo_alf) begin
                    issue_w0_c = 1'b1;
                end
            end
            ST_SEND: begin
                if (wcnt_q == WCNT_GAP) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end else begin
                    wr_d   = 1'b1;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    case (wcnt_q)
                        3'd1: data_d = {2'b11, 132'd0};
                        3'd2: data_d = {2'b11, 4'h0, snap_cmac_q, snap_lmac_q, ETH_TYPE,
                                        4'h0, MSG_TYPE_REPORT, 8'h00};
                        3'd3: data_d = {2'b11, 4'h0, snap_tsp_q, snap_dir_q, 31'd0,
                                        snap_tbp_q, 32'd0};
                        3'd4: data_d = {2'b11, 4'h0, snap_dmac_q, report_cnt_q, snap_gt_q, 16'd0};
                        3'd5: data_d = {2'b10, 132'd0};
                        default: data_d = '0;
                    endcase
                    if (wcnt_q == WCNT_TAIL) begin
                        valid_d      = 1'b1;
                        valid_wr_d   = 1'b1;
                        report_cnt_d = report_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
            end
        endcase

        if (issue_w0_c) begin
            state_d = ST_SEND;
            wcnt_d  = 3'd1;
            wr_d    = 1'b1;
            data_d  = {2'b01, 4'h0, LMID, BYTE_LEN, 108'd0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            pend_q       <= 1'b0;
            per_cnt_q    <= '0;
            bum_q        <= 1'b0;
            report_cnt_q <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
            valid_q      <= 1'b0;
            valid_wr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            pend_q       <= pend_d;
            per_cnt_q    <= per_cnt_d;
            bum_q        <= beacon_update_master;
            report_cnt_q <= report_cnt_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            valid_q      <= valid_d;
            valid_wr_q   <= valid_wr_d;
        end
    end

    // Field snapshot taken on the W0 edge keeps each packet self-consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_lmac_q <= '0;
            snap_cmac_q <= '0;
            snap_tsp_q  <= '0;
            snap_dir_q  <= 1'b0;
            snap_tbp_q  <= '0;
            snap_dmac_q <= '0;
            snap_gt_q   <= '0;
        end else if (issue_w0_c) begin
            snap_lmac_q <= in_local_mac_id;
            snap_cmac_q <= in_controller_mac;
            snap_tsp_q  <= in_time_slot_period;
            snap_dir_q  <= in_direction;
            snap_tbp_q  <= in_token_bucket_para;
            snap_dmac_q <= in_direct_mac_addr;
            snap_gt_q   <= in_global_time;
        end
    end

    assign out_lr_data          = data_q;
    assign out_lr_data_wr       = wr_q;
    assign out_lr_data_valid    = valid_q;
    assign out_lr_data_valid_wr = valid_wr_q;
    assign out_report_cnt       = report_cnt_q;

endmodule

// File: tb/tb_beacon_report_gen.sv
// Scoreboard bench for beacon_report_gen: stimulus pushes expected packets, a monitor
// assembles DUT packets and compares them word by word, including the W0 issue cycle.
module tb_beacon_report_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [47:0]  lmac, cmac, dmac, gtime;
    logic [31:0]  period, tsp, tbp;
    logic         bum, dir, alf;
    logic [133:0] out_lr_data;
    logic         out_lr_data_wr, out_lr_data_valid, out_lr_data_valid_wr;
    logic [15:0]  out_report_cnt;

    always #5 clk = ~clk;

    beacon_report_gen dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_local_mac_id      (lmac),
        .in_controller_mac    (cmac),
        .in_report_period     (period),
        .beacon_update_master (bum),
        .in_time_slot_period  (tsp),
        .in_direction         (dir),
        .in_token_bucket_para (tbp),
        .in_direct_mac_addr   (dmac),
        .in_global_time       (gtime),
        .in_lr_fifo_alf       (alf),
        .out_lr_data          (out_lr_data),
        .out_lr_data_wr       (out_lr_data_wr),
        .out_lr_data_valid    (out_lr_data_valid),
        .out_lr_data_valid_wr (out_lr_data_valid_wr),
        .out_report_cnt       (out_report_cnt)
    );

    typedef struct {
        logic [5:0][133:0] w;
        int                w0cyc;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          pkts   = 0;
    logic [15:0] seq_m  = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Reference packet built directly from the documented word layout.
    function automatic logic [5:0][133:0] build_pkt(input logic [15:0] seq);
        logic [5:0][133:0] p;
        p[0] = {2'b01, 4'h0, 8'd12, 12'd96, 108'd0};
        p[1] = {2'b11, 132'd0};
        p[2] = {2'b11, 4'h0, cmac, lmac, 16'h1662, 4'h0, 4'he, 8'h00};
        p[3] = {2'b11, 4'h0, tsp, dir, 31'd0, tbp, 32'd0};
        p[4] = {2'b11, 4'h0, dmac, seq, gtime, 16'd0};
        p[5] = {2'b10, 132'd0};
        return p;
    endfunction

    task automatic push_exp(input int w0);
        exp_t e;
        e.w     = build_pkt(seq_m);
        e.w0cyc = w0;
        expq.push_back(e);
        seq_m   = seq_m + 16'd1;
    endtask

    task automatic rand_fields();
        lmac  = 48'({$urandom(), $urandom()});
        cmac  = 48'({$urandom(), $urandom()});
        dmac  = 48'({$urandom(), $urandom()});
        gtime = 48'({$urandom(), $urandom()});
        tsp   = $urandom();
        tbp   = $urandom();
        dir   = 1'($urandom());
    endtask

    task automatic toggle_at(output int c);
        @(negedge clk);
        bum = ~bum;
        c   = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_pkts(input int n, input int budget);
        int k = 0;
        while (pkts < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (pkts < n) begin
            errors++;
            $display("FAIL pkt_timeout: got %0d packets expected %0d", pkts, n);
        end
    endtask

    // Monitor: assemble packets and compare against the scoreboard.
    logic [5:0][133:0] mbuf;
    logic [2:0]        widx = 3'd0;
    int                mw0  = 0;
    exp_t              mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            widx = 3'd0;
        end else if (out_lr_data_wr) begin
            if (widx == 3'd0) mw0 = cyc;
            mbuf[widx] = out_lr_data;
            chk("valid_flag", 134'(out_lr_data_valid), 134'(widx == 3'd5));
            chk("valid_wr_flag", 134'(out_lr_data_valid_wr), 134'(widx == 3'd5));
            if (widx == 3'd5) begin
                widx = 3'd0;
                pkts++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt: got packet at cycle %0d expected none", mw0);
                end else begin
                    mon_e = expq.pop_front();
                    for (int i = 0; i < 6; i++) begin
                        chk($sformatf("pkt%0d_w%0d", pkts, i), mbuf[3'(i)], mon_e.w[3'(i)]);
                    end
                    if (mon_e.w0cyc >= 0) chk($sformatf("pkt%0d_w0_cycle", pkts), 134'(mw0), 134'(mon_e.w0cyc));
                end
            end else begin
                widx = widx + 3'd1;
            end
        end else if (widx != 3'd0) begin
            checks++;
            errors++;
            $display("FAIL word_gap: got idle after %0d words expected 6 consecutive", widx);
            widx = 3'd0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int p0;
        rst_n  = 1'b0;
        bum    = 1'b0;
        alf    = 1'b0;
        period = 32'd0;
        rand_fields();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_data", out_lr_data, 134'd0);
        chk("rst_wr", 134'(out_lr_data_wr), 134'd0);
        chk("rst_valid", 134'(out_lr_data_valid), 134'd0);
        chk("rst_valid_wr", 134'(out_lr_data_valid_wr), 134'd0);
        chk("rst_cnt", 134'(out_report_cnt), 134'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single toggle with period disabled
        toggle_at(c);
        push_exp(c + 2);
        wait_pkts(1, 40);
        @(negedge clk);
        chk("cnt_after_first", 134'(out_report_cnt), 134'd1);

        // Randomised toggles; fields change mid-packet to exercise the snapshot
        for (int it = 0; it < 8; it++) begin
            rand_fields();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            p0 = pkts;
            toggle_at(c);
            push_exp(c + 2);
            wait_until(c + 3);
            rand_fields();
            wait_pkts(p0 + 1, 40);
        end
        @(negedge clk);
        chk("cnt_after_random", 134'(out_report_cnt), 134'(seq_m));

        // Periodic reports every 20 cycles
        @(negedge clk);
        period = 32'd20;
        c      = cyc;
        p0     = pkts;
        for (int k = 0; k < 5; k++) push_exp(c + 21 + 20 * k);
        wait_until(c + 105);
        period = 32'd0;
        wait_pkts(p0 + 5, 40);
        @(negedge clk);
        chk("cnt_after_period", 134'(out_report_cnt), 134'(seq_m));

        // Back-pressure, coalescing, toggle during SEND and snapshot of time_slot_period
        rand_fields();
        tsp = 32'h7a12;
        @(negedge clk);
        alf = 1'b1;
        bum = ~bum;
        c   = cyc;
        p0  = pkts;
        push_exp(c + 13);
        while (cyc < c + 12) begin
            @(negedge clk);
            if (cyc == c + 3) bum = ~bum;
            chk("alf_hold_wr", 134'(out_lr_data_wr), 134'd0);
        end
        alf = 1'b0;
        wait_until(c + 15);
        tsp = 32'h1000;
        bum = ~bum;
        push_exp(c + 20);
        wait_pkts(p0 + 2, 60);
        repeat (20) @(negedge clk);
        chk("alf_pkt_count", 134'(pkts), 134'(p0 + 2));
        chk("alf_queue_empty", 134'(expq.size()), 134'd0);

        // Report counter wrap
        @(negedge clk);
        force dut.report_cnt_q = 16'hffff;
        @(negedge clk);
        release dut.report_cnt_q;
        seq_m = 16'hffff;
        chk("cnt_preset", 134'(out_report_cnt), 134'hffff);
        rand_fields();
        p0 = pkts;
        toggle_at(c);
        push_exp(c + 2);
        wait_pkts(p0 + 1, 40);
        @(negedge clk);
        chk("cnt_wrap", 134'(out_report_cnt), 134'd0);

        // Reset during W3 aborts the packet
        p0 = pkts;
        toggle_at(c);
        wait_until(c + 5);
        #2;
        rst_n = 1'b0;
        bum   = 1'b0;
        #1;
        chk("abort_data", out_lr_data, 134'd0);
        chk("abort_wr", 134'(out_lr_data_wr), 134'd0);
        chk("abort_valid_wr", 134'(out_lr_data_valid_wr), 134'd0);
        chk("abort_cnt", 134'(out_report_cnt), 134'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_tail", 134'(pkts), 134'(p0));
        chk("abort_cnt_after", 134'(out_report_cnt), 134'd0);
        chk("final_queue_empty", 134'(expq.size()), 134'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
